// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the simple processor datapath.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // Execution-stage function codes. Only LOAD and STORE touch data memory.
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        ADD   = 3'd1,
        SUB   = 3'd2,
        LOAD  = 3'd3,
        STORE = 3'd4
    } func_t;

    // Data-memory access controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns LOAD/STORE ops from the execution
// stage into a held dmem request, stalls the pipeline while the access is
// outstanding, and reports completion, load data, misalignment or timeout.
//
// Handshake: an op is taken when valid_i & ready_o and func_i is LOAD/STORE.
// The dmem side sees dmem_req_o held high with stable addr/we/wdata until a
// single-cycle dmem_ack_i; an ack seen outside ACCESS has no effect.
module dmem_access_ctrl
    import simple_processor_pkg::*;
#(
    parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  func_t                 func_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  err_o,
    output logic                  dmem_req_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                  dmem_ack_i
);

    // A zero timeout disables the counter; keep it at least one bit wide.
    localparam int TC_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    dmem_state_t           state_q, state_d;
    logic [TC_W-1:0]       tcnt_q, tcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic is_mem_op;
    logic accept;
    logic aligned;

    assign is_mem_op = (func_i == LOAD) || (func_i == STORE);
    assign ready_o   = (state_q == IDLE) || (state_q == DONE);
    assign accept    = valid_i && ready_o && is_mem_op;
    assign aligned   = (addr_i[1:0] == 2'b00);

    // Next-state and timeout counter.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (!aligned) begin
                        state_d = ERR;
                    end else begin
                        state_d = ACCESS;
                        tcnt_d  = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Ack wins over a timeout reached in the same cycle.
                if (dmem_ack_i) begin
                    state_d = DONE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + TC_W'(1);
                    if (tcnt_d == TC_W'(TIMEOUT_CYCLES)) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and timeout counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Request latch on accept of an aligned op; load data capture on ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept && aligned) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= (func_i == STORE);
            end
            if ((state_q == ACCESS) && dmem_ack_i && !we_q) begin
                rdata_q <= dmem_rdata_i;
            end
        end
    end

    // Request outputs are forced low outside ACCESS so dmem sees clean zeros.
    always_comb begin
        dmem_req_o    = (state_q == ACCESS);
        dmem_addr_o   = dmem_req_o ? addr_q  : '0;
        dmem_we_o     = dmem_req_o ? we_q    : 1'b0;
        dmem_wdata_o  = dmem_req_o ? wdata_q : '0;
        done_o        = (state_q == DONE);
        rdata_valid_o = (state_q == DONE) && !we_q;
        err_o         = (state_q == ERR);
        stall_o       = (state_q == ACCESS) || accept || (state_q == ERR);
        rdata_o       = rdata_q;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with TIMEOUT_CYCLES = 16.
module tb_dmem_access_ctrl;
    import simple_processor_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    func_t       func_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .func_i(func_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .stall_o(stall_o),
        .done_o(done_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .err_o(err_o), .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Advance one cycle and settle past the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; func_i = NOP; addr_i = '0; wdata_i = '0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; idle_inputs();
        tick(); tick();
        rst_i = 1'b0; #1;
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", dmem_req_o); end
        total++; if (dmem_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", dmem_we_o); end
        total++; if (dmem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", dmem_addr_o); end
        total++; if (dmem_wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", dmem_wdata_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done_o); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
        total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", rdata_valid_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", ready_o); end
    endtask

    task automatic test_ack_ignored();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        tick();
        dmem_ack_i = 1'b0; #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL stray_ack_done got=%0b exp=0", done_o); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL stray_ack_rdata got=%h exp=0", rdata_o); end
    endtask

    task automatic test_load();
        int reqs = 0;
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0040; #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL load_accept_stall got=%0b exp=1", stall_o); end
        tick();
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            if (dmem_req_o === 1'b1) reqs++;
            total++; if (dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h40) begin bad++; $display("FAIL load_req_fields cyc=%0d we=%0b addr=%h exp we=0 addr=00000040", i, dmem_we_o, dmem_addr_o); end
            total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL load_stall cyc=%0d got=%0b exp=1", i, stall_o); end
            if (i == 3) begin dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF; end
            tick();
        end
        idle_inputs(); #1;
        total++; if (reqs != 3) begin bad++; $display("FAIL load_req_cycles got=%0d exp=3", reqs); end
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL load_done got=%0b exp=1", done_o); end
        total++; if (rdata_valid_o !== 1'b1) begin bad++; $display("FAIL load_rvalid got=%0b exp=1", rdata_valid_o); end
        total++; if (rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata_o); end
        total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL load_done_req_stall req=%0b stall=%0b exp 0 0", dmem_req_o, stall_o); end
        tick();
        total++; if (done_o !== 1'b0 || rdata_valid_o !== 1'b0) begin bad++; $display("FAIL load_pulse_once done=%0b rvalid=%0b exp 0 0", done_o, rdata_valid_o); end
        total++; if (rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata_hold got=%h exp=deadbeef", rdata_o); end
    endtask

    task automatic test_store();
        valid_i = 1'b1; func_i = STORE; addr_i = 32'h0000_0080; wdata_i = 32'h1234_5678;
        tick();
        idle_inputs(); #1;
        total++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin bad++; $display("FAIL store_req req=%0b we=%0b exp 1 1", dmem_req_o, dmem_we_o); end
        total++; if (dmem_addr_o !== 32'h80 || dmem_wdata_o !== 32'h1234_5678) begin bad++; $display("FAIL store_fields addr=%h wdata=%h exp 00000080 12345678", dmem_addr_o, dmem_wdata_o); end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        tick();
        idle_inputs(); #1;
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL store_done got=%0b exp=1", done_o); end
        total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL store_rvalid got=%0b exp=0", rdata_valid_o); end
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL store_one_req got=%0b exp=0", dmem_req_o); end
        total++; if (rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_rdata_kept got=%h exp=deadbeef", rdata_o); end
        tick();
    endtask

    task automatic test_timeout();
        int reqs = 0;
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0100;
        tick();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            if (dmem_req_o !== 1'b1) break;
            reqs++;
            total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_early_err cyc=%0d got=%0b exp=0", reqs, err_o); end
            tick();
        end
        total++; if (reqs != 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", reqs); end
        total++; if (err_o !== 1'b1 || stall_o !== 1'b1 || ready_o !== 1'b0) begin bad++; $display("FAIL to_err err=%0b stall=%0b ready=%0b exp 1 1 0", err_o, stall_o, ready_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL to_done got=%0b exp=0", done_o); end
        tick();
        total++; if (err_o !== 1'b0 || ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL to_idle err=%0b ready=%0b req=%0b exp 0 1 0", err_o, ready_o, dmem_req_o); end
        // Ack arriving on the sixteenth request cycle must complete normally.
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0104;
        tick();
        idle_inputs();
        for (int i = 1; i <= 15; i++) tick();
        total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL to16_req got=%0b exp=1", dmem_req_o); end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
        tick();
        idle_inputs(); #1;
        total++; if (done_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("FAIL to16_ack done=%0b err=%0b exp 1 0", done_o, err_o); end
        total++; if (rdata_o !== 32'h0BAD_F00D) begin bad++; $display("FAIL to16_rdata got=%h exp=0badf00d", rdata_o); end
        tick();
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to16_late_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_misaligned();
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0042; #1;
        total++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL mis_accept stall=%0b req=%0b exp 1 0", stall_o, dmem_req_o); end
        tick();
        idle_inputs(); #1;
        total++; if (err_o !== 1'b1 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL mis_err err=%0b req=%0b exp 1 0", err_o, dmem_req_o); end
        tick();
        total++; if (err_o !== 1'b0 || dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL mis_after err=%0b req=%0b ready=%0b exp 0 0 1", err_o, dmem_req_o, ready_o); end
    endtask

    task automatic test_back_to_back();
        valid_i = 1'b1; func_i = STORE; addr_i = 32'h0000_0200; wdata_i = 32'hA5A5_0001;
        tick();
        idle_inputs();
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0204; #1;
        total++; if (done_o !== 1'b1 || ready_o !== 1'b1 || stall_o !== 1'b1) begin bad++; $display("FAIL b2b_done_accept done=%0b ready=%0b stall=%0b exp 1 1 1", done_o, ready_o, stall_o); end
        tick();
        idle_inputs(); #1;
        total++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h204) begin bad++; $display("FAIL b2b_req req=%0b we=%0b addr=%h exp 1 0 00000204", dmem_req_o, dmem_we_o, dmem_addr_o); end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        tick();
        idle_inputs(); #1;
        total++; if (done_o !== 1'b1 || rdata_valid_o !== 1'b1 || rdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_load done=%0b rvalid=%0b rdata=%h exp 1 1 cafef00d", done_o, rdata_valid_o, rdata_o); end
        // Non-memory op offered in DONE: passes through with no request.
        valid_i = 1'b1; func_i = ADD; addr_i = 32'h0000_0300; #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL add_stall got=%0b exp=0", stall_o); end
        tick();
        total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL add_idle req=%0b stall=%0b ready=%0b exp 0 0 1", dmem_req_o, stall_o, ready_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        valid_i = 1'b1; func_i = LOAD; addr_i = 32'h0000_0300;
        tick();
        idle_inputs(); #1;
        total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL rmid_req got=%0b exp=1", dmem_req_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; #1;
        total++; if (dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL rmid_drop req=%0b ready=%0b exp 0 1", dmem_req_o, ready_o); end
        total++; if (done_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL rmid_flags done=%0b err=%0b exp 0 0", done_o, err_o); end
        tick();
        total++; if (done_o !== 1'b0 || err_o !== 1'b0 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL rmid_after done=%0b err=%0b req=%0b exp 0 0 0", done_o, err_o, dmem_req_o); end
    endtask

    initial begin
        test_reset();
        test_ack_ignored();
        test_load();
        test_store();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
